minterm_sweep_checker: RTL and testbench
========================================

Name: minterm_sweep_checker

Overview:
Sequential stimulus-and-check stage wrapped around a pair of 2-input gate implementations (structural and expression forms of the same function).
- Upstream role: drives every input minterm in ascending order onto the gates' shared inputs.
- Downstream role: after a settle window, samples both gate outputs, compares them to an expected truth table and to each other, and accumulates a pass/fail result.
- Replaces free-running timed stimulus with a clocked, self-checking sweep.

Parameters:
- N_IN, 2: number of gate inputs; the sweep covers minterms 0 .. 2^N_IN-1.
- SETTLE, 1: extra cycles the stimulus is held before the outputs are sampled (0 allowed).
- EXPECT, 4'b0001: expected output truth table, width 2^N_IN; bit m is the required output for minterm m. The default is NOR.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  pulse or level; starts a sweep when sampled high in IDLE or DONE.
- a_in  in  1  output of implementation A.
- b_in  in  1  output of implementation B.
- x_out  out  N_IN  stimulus; current minterm, MSB = first gate input.
- busy  out  1  high in APPLY and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  N_IN+1  number of minterms that failed.
- fail_a  out  1  sticky; A mismatched EXPECT at least once.
- fail_b  out  1  sticky; B mismatched EXPECT at least once.
- first_fail  out  N_IN  minterm of the first failure; 0 if none.

Behaviour:
- Reset (async, immediate): state=IDLE, x_out=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, first_fail=0, settle cnt=0.
- Reset asserted mid-sweep aborts the sweep; no partial result is retained.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE --start--> APPLY:
  - clears err_count, fail_a, fail_b, first_fail, cnt;
  - sets x_out=0.
- APPLY:
  - x_out is held;
  - if cnt==SETTLE, go to CHECK; else cnt++;
  - APPLY therefore lasts SETTLE+1 cycles.
- CHECK (1 cycle, x_out still held): at the edge leaving CHECK, a_in and b_in are sampled.
  - mA = a_in!=EXPECT[x_out]; mB = b_in!=EXPECT[x_out].
  - If mA|mB: err_count++; fail_a|=mA; fail_b|=mB; if this is the first failure, first_fail=x_out.
  - A==B with both wrong counts as a failure.
  - If x_out==2^N_IN-1, go to DONE; else x_out++, cnt=0, go to APPLY.
- Per-minterm cost is SETTLE+2 cycles. The edge that samples start is E0; done rises at edge E0 + 2^N_IN*(SETTLE+2) (12 for the defaults).
- DONE:
  - results and x_out are held stable;
  - start re-launches the sweep (identical to the IDLE exit);
  - without start, DONE persists.
- start is ignored while busy; no restart and no queueing.
- err_count never overflows: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- pass=0 outside DONE.

Decomposition:
- Shared package:
  - state enum {IDLE, APPLY, CHECK, DONE};
  - localparam NOR2_TT=4'b0001;
  - also NAND2_TT, AND2_TT, OR2_TT for reuse by sibling checkers.
- Sub-module minterm_counter (N_IN-bit up counter with clear, enable and terminal-count flag): drives x_out and the CHECK→DONE decision.
- The settle counter and FSM stay in the top level.

Test Plan:
1. Defaults, correct NOR on both A and B, start pulse → x_out steps 0,1,2,3, each held 3 cycles; done at E0+12; pass=1, err_count=0, fail_a=0, fail_b=0.
2. A stuck-at-0, B correct NOR → only minterm 0 fails; err_count=1, fail_a=1, fail_b=0, first_fail=0, pass=0.
3. B = inverted NOR → err_count=4, fail_b=1, fail_a=0, first_fail=0; then a second start with correct gates gives pass=1 and all counters cleared.
4. SETTLE=0 → each minterm held 2 cycles; done at E0+8. SETTLE=3 → done at E0+20.
5. rst raised during APPLY of minterm 2, start pulsed during busy → all outputs zero immediately on reset; the mid-sweep start has no effect; a start after reset release runs a full 12-cycle sweep.
6. N_IN=3, EXPECT=8'h01 (NOR3), A fails only at minterm 5 → x_out covers 0..7; err_count=1, first_fail=5, done at E0+24.

Source files
------------

// File: rtl/minterm_sweep_checker_pkg.sv
// ---------------------------------------------------------------------------
// minterm_sweep_checker_pkg
// Shared types and constants for the minterm sweep checkers.
//   state_t      : sweep controller states
//   *_TT         : 2-input truth tables, bit m = output for minterm m
//   settle_width : width of a counter that must reach the value 'settle'
// ---------------------------------------------------------------------------
package minterm_sweep_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NOR2_TT  = 4'b0001;
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;

  // A settle count of 0 still needs a 1-bit register to stay legal.
  function automatic int settle_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/minterm_sweep_checker_minterm_counter.sv
// ---------------------------------------------------------------------------
// minterm_counter
// W-bit up counter producing the current minterm.
//   clk, rst  : clock and async active-high reset
//   clear     : synchronous return to 0 (wins over enable)
//   enable    : advance by one
//   count     : current minterm
//   terminal  : count is at its all-ones value (last minterm)
// ---------------------------------------------------------------------------
module minterm_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = &count;

endmodule

// File: rtl/minterm_sweep_checker.sv
// ---------------------------------------------------------------------------
// minterm_sweep_checker
// Drives every input minterm in ascending order onto two gate
// implementations, waits a settle window, samples both outputs and checks
// them against the expected truth table, accumulating a pass/fail result.
//   clk, rst     : clock and async active-high reset
//   start        : launches a sweep when seen in IDLE or DONE
//   a_in, b_in   : outputs of implementations A and B
//   x_out        : current minterm (MSB = first gate input)
//   busy         : sweep in progress (APPLY or CHECK)
//   done         : sweep finished, results stable
//   pass         : valid while done; no minterm failed
//   err_count    : number of failing minterms
//   fail_a/b     : sticky per-implementation mismatch flags
//   first_fail   : minterm of the first failure, 0 if none
// ---------------------------------------------------------------------------
module minterm_sweep_checker
  import minterm_sweep_checker_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECT = NOR2_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            a_in,
  input  logic            b_in,
  output logic [N_IN-1:0] x_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_a,
  output logic            fail_b,
  output logic [N_IN-1:0] first_fail
);

  localparam int             CW          = settle_width(SETTLE);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          launch;
  logic          step;
  logic          last;
  logic          exp_bit;
  logic          mis_a;
  logic          mis_b;

  // Minterm stimulus: cleared on launch, advanced when a non-final CHECK ends.
  minterm_counter #(.W(N_IN)) u_minterm_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .enable   (step),
    .count    (x_out),
    .terminal (last)
  );

  assign exp_bit = EXPECT[x_out];
  assign mis_a   = (a_in != exp_bit);
  assign mis_b   = (b_in != exp_bit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only honoured in IDLE/DONE, so a pulse
  // during the sweep is simply dropped.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (cnt == SETTLE_LAST) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (last) begin
          state_next = DONE;
        end else begin
          step       = 1'b1;
          state_next = APPLY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Settle counter: APPLY lasts SETTLE+1 cycles per minterm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (launch || step) begin
      cnt <= '0;
    end else if (state == APPLY && cnt != SETTLE_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result accumulation. A minterm where both implementations agree but are
  // both wrong still counts once. first_fail latches while the count is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      fail_a     <= 1'b0;
      fail_b     <= 1'b0;
      first_fail <= '0;
    end else if (launch) begin
      err_count  <= '0;
      fail_a     <= 1'b0;
      fail_b     <= 1'b0;
      first_fail <= '0;
    end else if (state == CHECK && (mis_a || mis_b)) begin
      err_count <= err_count + 1'b1;
      fail_a    <= fail_a | mis_a;
      fail_b    <= fail_b | mis_b;
      if (err_count == '0) begin
        first_fail <= x_out;
      end
    end
  end

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_minterm_sweep_checker
// Four instances of the checker (defaults, SETTLE=0, SETTLE=3, N_IN=3 NOR3)
// driven by modelled NOR gates with per-minterm fault masks. Expected
// results come from walking the truth table in plain arithmetic.
// ---------------------------------------------------------------------------
module tb_minterm_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_vec;
  logic [7:0] flip_a;
  logic [7:0] flip_b;

  int checks   = 0;
  int failures = 0;
  int sel;

  always #5 clk = ~clk;

  // Instance 0: defaults
  logic [1:0] x0, ff0;
  logic [2:0] err0;
  logic a0, b0, busy0, done0, pass0, fa0, fb0;
  // Instance 1: SETTLE=0
  logic [1:0] x1, ff1;
  logic [2:0] err1;
  logic a1, b1, busy1, done1, pass1, fa1, fb1;
  // Instance 2: SETTLE=3
  logic [1:0] x2, ff2;
  logic [2:0] err2;
  logic a2, b2, busy2, done2, pass2, fa2, fb2;
  // Instance 3: N_IN=3, NOR3
  logic [2:0] x3, ff3;
  logic [3:0] err3;
  logic a3, b3, busy3, done3, pass3, fa3, fb3;

  // Modelled gates: NOR of the minterm, optionally flipped per minterm.
  assign a0 = (x0 == 2'd0) ^ flip_a[x0];
  assign b0 = (x0 == 2'd0) ^ flip_b[x0];
  assign a1 = (x1 == 2'd0) ^ flip_a[x1];
  assign b1 = (x1 == 2'd0) ^ flip_b[x1];
  assign a2 = (x2 == 2'd0) ^ flip_a[x2];
  assign b2 = (x2 == 2'd0) ^ flip_b[x2];
  assign a3 = (x3 == 3'd0) ^ flip_a[x3];
  assign b3 = (x3 == 3'd0) ^ flip_b[x3];

  minterm_sweep_checker u_def (
    .clk(clk), .rst(rst), .start(start_vec[0]), .a_in(a0), .b_in(b0),
    .x_out(x0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0), .first_fail(ff0));

  minterm_sweep_checker #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_vec[1]), .a_in(a1), .b_in(b1),
    .x_out(x1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1), .first_fail(ff1));

  minterm_sweep_checker #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start_vec[2]), .a_in(a2), .b_in(b2),
    .x_out(x2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2), .first_fail(ff2));

  minterm_sweep_checker #(.N_IN(3), .EXPECT(8'h01)) u_n3 (
    .clk(clk), .rst(rst), .start(start_vec[3]), .a_in(a3), .b_in(b3),
    .x_out(x3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_a(fa3), .fail_b(fb3), .first_fail(ff3));

  // Selected-instance view used by the tests.
  logic [2:0] s_x, s_ff;
  logic [3:0] s_err;
  logic       s_busy, s_done, s_pass, s_fa, s_fb;

  always_comb begin
    s_x = '0; s_ff = '0; s_err = '0;
    s_busy = 1'b0; s_done = 1'b0; s_pass = 1'b0; s_fa = 1'b0; s_fb = 1'b0;
    case (sel)
      0: begin s_x = {1'b0, x0}; s_ff = {1'b0, ff0}; s_err = {1'b0, err0};
               s_busy = busy0; s_done = done0; s_pass = pass0; s_fa = fa0; s_fb = fb0; end
      1: begin s_x = {1'b0, x1}; s_ff = {1'b0, ff1}; s_err = {1'b0, err1};
               s_busy = busy1; s_done = done1; s_pass = pass1; s_fa = fa1; s_fb = fb1; end
      2: begin s_x = {1'b0, x2}; s_ff = {1'b0, ff2}; s_err = {1'b0, err2};
               s_busy = busy2; s_done = done2; s_pass = pass2; s_fa = fa2; s_fb = fb2; end
      default: begin s_x = x3; s_ff = ff3; s_err = err3;
               s_busy = busy3; s_done = done3; s_pass = pass3; s_fa = fa3; s_fb = fb3; end
    endcase
  end

  function automatic int settle_of(input int s);
    case (s)
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int nin_of(input int s);
    return (s == 3) ? 3 : 2;
  endfunction

  // One full sweep on instance s with fault masks fa/fb. With noise set,
  // start is pulsed once mid-sweep and must be ignored.
  task automatic run_sweep(input int s, input logic [7:0] fa, input logic [7:0] fb,
                           input bit noise, input string name);
    int settle, nmin, k, n, noise_n, exp_err, exp_ff;
    bit exp_fa, exp_fb, ma, mb, exp_bit, gate_a, gate_b, timed_out;
    logic [3:0] hold_err;
    sel     = s;
    settle  = settle_of(s);
    nmin    = 1 << nin_of(s);
    k       = nmin * (settle + 2);
    flip_a  = fa;
    flip_b  = fb;
    exp_err = 0; exp_ff = 0; exp_fa = 0; exp_fb = 0;
    // Reference: NOR is 1 only at minterm 0 for any width.
    for (int m = 0; m < nmin; m++) begin
      exp_bit = (m == 0);
      gate_a  = (m == 0) ^ fa[m];
      gate_b  = (m == 0) ^ fb[m];
      ma = (gate_a != exp_bit);
      mb = (gate_b != exp_bit);
      if (ma || mb) begin
        if (exp_err == 0) exp_ff = m;
        exp_err++;
      end
      exp_fa |= ma;
      exp_fb |= mb;
    end
    noise_n = noise ? int'($urandom_range(k - 2, 1)) : -1;

    @(negedge clk); start_vec[s] = 1'b1;
    @(negedge clk); start_vec[s] = 1'b0;
    n = 0;
    timed_out = 0;
    while (!s_done) begin
      checks++;
      if (s_x !== 3'(n / (settle + 2)) || s_busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s x_seq cycle %0d: got x=%0d busy=%b, expected x=%0d busy=1",
                 name, n, s_x, s_busy, n / (settle + 2));
      end
      start_vec[s] = (n == noise_n);
      @(negedge clk);
      n++;
      if (n > 100) begin timed_out = 1; break; end
    end
    start_vec = '0;

    checks++;
    if (timed_out || n != k) begin
      failures++;
      $display("[TB] FAIL %s done_time: got %0d cycles (timeout=%0d), expected %0d",
               name, n, timed_out, k);
    end
    checks++;
    if (s_err !== 4'(exp_err) || s_fa !== exp_fa || s_fb !== exp_fb ||
        s_ff !== 3'(exp_ff) || s_pass !== (exp_err == 0)) begin
      failures++;
      $display("[TB] FAIL %s result: got err=%0d fa=%b fb=%b ff=%0d pass=%b, expected err=%0d fa=%b fb=%b ff=%0d pass=%b",
               name, s_err, s_fa, s_fb, s_ff, s_pass, exp_err, exp_fa, exp_fb, exp_ff, exp_err == 0);
    end
    checks++;
    if (s_x !== 3'(nmin - 1) || s_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s final_x: got x=%0d busy=%b, expected x=%0d busy=0",
               name, s_x, s_busy, nmin - 1);
    end
    // DONE must persist with results stable while start stays low.
    hold_err = s_err;
    repeat (3) @(negedge clk);
    checks++;
    if (s_done !== 1'b1 || s_err !== 4'(exp_err) || s_x !== 3'(nmin - 1)) begin
      failures++;
      $display("[TB] FAIL %s done_hold: got done=%b err=%0d x=%0d, expected done=1 err=%0d x=%0d",
               name, s_done, s_err, s_x, hold_err, nmin - 1);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (s_x !== 3'd0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_pass !== 1'b0 ||
          s_err !== 4'd0 || s_fa !== 1'b0 || s_fb !== 1'b0 || s_ff !== 3'd0) begin
        failures++;
        $display("[TB] FAIL %s inst%0d: got x=%0d busy=%b done=%b pass=%b err=%0d fa=%b fb=%b ff=%0d, expected all 0",
                 name, s, s_x, s_busy, s_done, s_pass, s_err, s_fa, s_fb, s_ff);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_vec = '0; flip_a = '0; flip_b = '0; sel = 0;
    #2;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nor_correct();
    run_sweep(0, 8'h00, 8'h00, 0, "nor_correct");
  endtask

  task automatic test_a_stuck0();
    run_sweep(0, 8'h01, 8'h00, 0, "a_stuck0");
  endtask

  task automatic test_b_inverted_restart();
    run_sweep(0, 8'h00, 8'h0F, 0, "b_inverted");
    run_sweep(0, 8'h00, 8'h00, 0, "restart_clean");
  endtask

  task automatic test_settle_variants();
    run_sweep(1, 8'h00, 8'h00, 0, "settle0");
    run_sweep(2, 8'h00, 8'h00, 0, "settle3");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    sel = 0; flip_a = 8'h01; flip_b = 8'h00;
    @(negedge clk); start_vec[0] = 1'b1;
    @(negedge clk); start_vec[0] = 1'b0;
    // x=1 is shown at cycles 3..5, x=2 in APPLY at cycles 6..7.
    for (n = 0; n < 7; n++) begin
      start_vec[0] = (n == 4);
      @(negedge clk);
    end
    start_vec = '0;
    checks++;
    if (s_x !== 3'd2 || s_busy !== 1'b1 || s_err !== 4'd1) begin
      failures++;
      $display("[TB] FAIL mid_sweep_pre: got x=%0d busy=%b err=%0d, expected x=2 busy=1 err=1",
               s_x, s_busy, s_err);
    end
    rst = 1'b1;
    check_all_zero("reset_async");
    @(negedge clk); rst = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_x !== 3'd0) begin
      failures++;
      $display("[TB] FAIL no_queued_start: got busy=%b done=%b x=%0d, expected busy=0 done=0 x=0",
               s_busy, s_done, s_x);
    end
    run_sweep(0, 8'h00, 8'h00, 0, "after_reset");
  endtask

  task automatic test_nor3();
    run_sweep(3, 8'h20, 8'h00, 0, "nor3_a_fail5");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_sweep(int'($urandom_range(3, 0)), 8'($urandom), 8'($urandom), 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_nor_correct();
    test_a_stuck0();
    test_b_inverted_restart();
    test_settle_variants();
    test_reset_mid_sweep();
    test_nor3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
